// File: rtl/mc_chroma_ref_fetch4x4_if.sv
// Bus bundle for the 4x4 chroma reference-window fetcher: block request,
// reference-buffer read port and aligned-row output toward the interpolator.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

interface mc_chroma_ref_fetch4x4_if #(
   parameter int ROW_PIX = 16,
   parameter int ADDR_W  = 6
);
   localparam int PW = `PIXEL_WIDTH;
   localparam int XW = $clog2(ROW_PIX);

   logic                    start_i;
   logic [XW-1:0]           ref_x_i;
   logic [ADDR_W-1:0]       ref_y_i;
   logic [ADDR_W-1:0]       base_addr_i;
   logic [5:0]              frac_i;
   logic                    rd_en_o;
   logic [ADDR_W-1:0]       rd_addr_o;
   logic [ROW_PIX*PW-1:0]   rd_data_i;
   logic                    busy_o;
   logic                    blk_start_o;
   logic [5:0]              frac_o;
   logic                    refuv_valid_o;
   logic [PW-1:0]           refuv_p0_o;
   logic [PW-1:0]           refuv_p1_o;
   logic [PW-1:0]           refuv_p2_o;
   logic [PW-1:0]           refuv_p3_o;
   logic [PW-1:0]           refuv_p4_o;
   logic [PW-1:0]           refuv_p5_o;
   logic [PW-1:0]           refuv_p6_o;
   logic                    done_o;

   modport slave (
      input  start_i, ref_x_i, ref_y_i, base_addr_i, frac_i, rd_data_i,
      output rd_en_o, rd_addr_o, busy_o, blk_start_o, frac_o, refuv_valid_o,
             refuv_p0_o, refuv_p1_o, refuv_p2_o, refuv_p3_o, refuv_p4_o,
             refuv_p5_o, refuv_p6_o, done_o
   );

   modport master (
      output start_i, ref_x_i, ref_y_i, base_addr_i, frac_i, rd_data_i,
      input  rd_en_o, rd_addr_o, busy_o, blk_start_o, frac_o, refuv_valid_o,
             refuv_p0_o, refuv_p1_o, refuv_p2_o, refuv_p3_o, refuv_p4_o,
             refuv_p5_o, refuv_p6_o, done_o
   );
endinterface

// File: rtl/mc_chroma_ref_fetch4x4.sv
// Fetches a 7x7 chroma reference window (7 buffer reads) and emits column-aligned rows.
// Optional MC_CHROMA_REF_PAD_EN: clamp columns to the row end instead of wrapping.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module mc_chroma_ref_fetch4x4 #(
   parameter int ROW_PIX = 16,
   parameter int ADDR_W  = 6
) (
   input  logic                      clk,
   input  logic                      rstn,
   mc_chroma_ref_fetch4x4_if.slave   bus
);
   localparam int PW = `PIXEL_WIDTH;
   localparam int XW = $clog2(ROW_PIX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          row_q, row_d;
   logic [XW-1:0]       x_q, x_d;
   logic [5:0]          frac_q, frac_d;
   logic                rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                blk_start_q, blk_start_d;
   logic                busy_q, busy_d;
   logic                vld1_q, vld1_d;
   logic                last1_q, last1_d;
   logic                valid_q, valid_d;
   logic                done_q, done_d;
   logic [PW-1:0]       pix_q [7];
   logic [PW-1:0]       pix_d [7];
   logic [XW-1:0]       col_s [7];

   function automatic logic [PW-1:0] pick_pix(input logic [ROW_PIX*PW-1:0] word,
                                              input logic [XW-1:0] idx);
      pick_pix = word[(ROW_PIX - 1 - int'(idx)) * PW +: PW];
   endfunction

   // Control FSM: accept a request, issue seven row reads, wait for the pipeline to empty.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      x_d         = x_q;
      frac_d      = frac_q;
      rd_en_d     = 1'b0;
      rd_addr_d   = rd_addr_q;
      blk_start_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               state_d     = READ;
               x_d         = bus.ref_x_i;
               frac_d      = bus.frac_i;
               row_d       = 3'd0;
               rd_en_d     = 1'b1;
               rd_addr_d   = bus.base_addr_i + bus.ref_y_i;
               blk_start_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            if (row_q == 3'd6) begin
               state_d = DRAIN;
               row_d   = 3'd0;
            end else begin
               row_d     = row_q + 3'd1;
               rd_en_d   = 1'b1;
               rd_addr_d = rd_addr_q + ADDR_W'(1);
            end
         end
         DRAIN: begin
            if (done_q) begin
               state_d = IDLE;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d  = (state_d != IDLE);
      vld1_d  = rd_en_q;
      last1_d = rd_en_q && (row_q == 3'd6);
      valid_d = vld1_q;
      done_d  = last1_q;
   end

   // Stage-2 column select: pk = word pixel at x + k, wrapped or clamped at the row end.
   always_comb begin
      for (int k = 0; k < 7; k++) begin
`ifdef MC_CHROMA_REF_PAD_EN
         logic [XW:0] sum;
         sum      = {1'b0, x_q} + (XW+1)'(k);
         col_s[k] = sum[XW] ? XW'(ROW_PIX - 1) : sum[XW-1:0];
`else
         col_s[k] = x_q + XW'(k);
`endif
         if (vld1_q) begin
            pix_d[k] = pick_pix(bus.rd_data_i, col_s[k]);
         end else begin
            pix_d[k] = pix_q[k];
         end
      end
   end

   // State, read-port and output pipeline registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         row_q       <= 3'd0;
         x_q         <= '0;
         frac_q      <= 6'd0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         blk_start_q <= 1'b0;
         busy_q      <= 1'b0;
         vld1_q      <= 1'b0;
         last1_q     <= 1'b0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         for (int k = 0; k < 7; k++) begin
            pix_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         x_q         <= x_d;
         frac_q      <= frac_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         blk_start_q <= blk_start_d;
         busy_q      <= busy_d;
         vld1_q      <= vld1_d;
         last1_q     <= last1_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
         for (int k = 0; k < 7; k++) begin
            pix_q[k] <= pix_d[k];
         end
      end
   end

   assign bus.rd_en_o       = rd_en_q;
   assign bus.rd_addr_o     = rd_addr_q;
   assign bus.busy_o        = busy_q;
   assign bus.blk_start_o   = blk_start_q;
   assign bus.frac_o        = frac_q;
   assign bus.refuv_valid_o = valid_q;
   assign bus.done_o        = done_q;
   assign bus.refuv_p0_o    = pix_q[0];
   assign bus.refuv_p1_o    = pix_q[1];
   assign bus.refuv_p2_o    = pix_q[2];
   assign bus.refuv_p3_o    = pix_q[3];
   assign bus.refuv_p4_o    = pix_q[4];
   assign bus.refuv_p5_o    = pix_q[5];
   assign bus.refuv_p6_o    = pix_q[6];
endmodule
